// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: two line RAMs plus a shift window feed a
// registered 9-pixel output with ready/valid backpressure and a frame FSM.
module conv_window_gen #(
    parameter int IMG_WIDTH  = 224,
    parameter int IMG_HEIGHT = 224,
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   pixel_in,
    input  logic                    pixel_in_valid,
    output logic                    pixel_in_ready,
    output logic [9*DATA_WIDTH-1:0] window_out,
    output logic                    window_valid,
    input  logic                    window_ready,
    output logic                    frame_done,
    output logic                    busy
);
    localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [10:0] LAST_COL = 11'(IMG_WIDTH - 1);
    localparam logic [10:0] LAST_ROW = 11'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                  state_q;
    logic [10:0]             col_q;
    logic [10:0]             row_q;
    logic [DATA_WIDTH-1:0]   lb0_mem [IMG_WIDTH];
    logic [DATA_WIDTH-1:0]   lb1_mem [IMG_WIDTH];
    logic [DATA_WIDTH-1:0]   col_new [3];
    logic [9*DATA_WIDTH-1:0] window_d;
    logic [9*DATA_WIDTH-1:0] window_q;
    logic                    window_valid_q;
    logic [AW-1:0]           addr;
    logic                    acc;
    logic                    emit;

    assign pixel_in_ready = (state_q == RUN) && (!window_valid_q || window_ready);
    assign acc            = pixel_in_valid && pixel_in_ready;
    assign emit           = acc && (row_q >= 11'd2) && (col_q >= 11'd2);
    assign addr           = col_q[AW-1:0];
    assign window_out     = window_q;
    assign window_valid   = window_valid_q;
    assign frame_done     = (state_q == DONE);
    assign busy           = (state_q == RUN) || (state_q == DRAIN);

    // Incoming column, oldest row first.
    assign col_new[0] = lb1_mem[addr];
    assign col_new[1] = lb0_mem[addr];
    assign col_new[2] = pixel_in;

    // Read-before-write: the old LB0 entry migrates to LB1 as the new pixel lands.
    always_ff @(posedge clk) begin
        if (acc) begin
            lb1_mem[addr] <= lb0_mem[addr];
            lb0_mem[addr] <= pixel_in;
        end
    end

    // Each row only needs its two most recent columns; the third comes from col_new.
    for (genvar gi = 0; gi < 3; gi++) begin : g_row
        logic [DATA_WIDTH-1:0] tap_q [2];

        always_ff @(posedge clk) begin
            if (reset) begin
                tap_q[0] <= '0;
                tap_q[1] <= '0;
            end else if (acc) begin
                tap_q[0] <= tap_q[1];
                tap_q[1] <= col_new[gi];
            end
        end

        assign window_d[(3*gi+0)*DATA_WIDTH +: DATA_WIDTH] = tap_q[0];
        assign window_d[(3*gi+1)*DATA_WIDTH +: DATA_WIDTH] = tap_q[1];
        assign window_d[(3*gi+2)*DATA_WIDTH +: DATA_WIDTH] = col_new[gi];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            window_q       <= '0;
            window_valid_q <= 1'b0;
        end else if (emit) begin
            window_q       <= window_d;
            window_valid_q <= 1'b1;
        end else if (window_ready) begin
            window_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    col_q <= '0;
                    row_q <= '0;
                    if (start) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (acc) begin
                        if (col_q == LAST_COL) begin
                            col_q <= '0;
                            if (row_q == LAST_ROW) begin
                                state_q <= DRAIN;
                            end else begin
                                row_q <= row_q + 11'd1;
                            end
                        end else begin
                            col_q <= col_q + 11'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (!window_valid_q || window_ready) begin
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 5x4 frame whose pixel value equals its raster index.
module tb_conv_window_gen;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  pixel_in;
    logic        pixel_in_valid;
    logic        pixel_in_ready;
    logic [71:0] window_out;
    logic        window_valid;
    logic        window_ready;
    logic        frame_done;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [71:0] FIRST_WIN = {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0};
    localparam logic [71:0] LAST_WIN  = {8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12, 8'd9, 8'd8, 8'd7};

    conv_window_gen #(
        .IMG_WIDTH (5),
        .IMG_HEIGHT(4),
        .DATA_WIDTH(8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .pixel_in      (pixel_in),
        .pixel_in_valid(pixel_in_valid),
        .pixel_in_ready(pixel_in_ready),
        .window_out    (window_out),
        .window_valid  (window_valid),
        .window_ready  (window_ready),
        .frame_done    (frame_done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Window n of the frame: output pixel (r,c) with r = 2 + n/3, c = 2 + n%3.
    function automatic logic [71:0] exp_win(input int n);
        logic [71:0] w;
        int r;
        int c;
        w = '0;
        r = 2 + n / 3;
        c = 2 + n % 3;
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++)
                w[(3*dy+dx)*8 +: 8] = 8'(5 * (r - 2 + dy) + (c - 2 + dx));
        return w;
    endfunction

    task automatic do_start(input bit hold);
        @(negedge clk);
        start = 1'b1;
        pixel_in_valid = 1'b0;
        @(negedge clk);
        start = hold;
        check("start_busy", 72'(busy), 72'd1);
    endtask

    task automatic run_frame(input int ready_mode, input int gap_mode, input bit hold_start,
                             input string tag);
        int          pix = 0;
        int          got = 0;
        int          cyc = 0;
        int          first_pix = -1;
        bit          prev_stall = 1'b0;
        bit          done_seen = 1'b0;
        logic [71:0] prev_win = '0;
        logic [71:0] first_win = '0;
        logic [71:0] last_win = '0;
        while (cyc < 400) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                done_seen = 1'b1;
                break;
            end
            if (prev_stall) begin
                check({tag, "_hold_valid"}, 72'(window_valid), 72'd1);
                check({tag, "_hold_data"}, window_out, prev_win);
            end
            window_ready   = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
            pixel_in_valid = (pix < 20) && (gap_mode == 0 || $urandom_range(0, 2) != 0);
            pixel_in       = 8'(pix);
            start          = hold_start && (pix < 20);
            #1;
            check({tag, "_ready"}, 72'(pixel_in_ready),
                  72'((pix < 20) && (!window_valid || window_ready)));
            if (window_valid && first_pix < 0) first_pix = pix;
            if (window_valid && window_ready) begin
                check({tag, "_window"}, window_out, exp_win(got));
                $display("%s window %0d: %h", tag, got, window_out);
                if (got == 0) first_win = window_out;
                last_win = window_out;
                got++;
            end
            prev_stall = window_valid && !window_ready;
            prev_win   = window_out;
            if (pixel_in_valid && pixel_in_ready) pix++;
            cyc++;
        end
        pixel_in_valid = 1'b0;
        start = 1'b0;
        window_ready = 1'b1;
        check({tag, "_done_seen"}, 72'(done_seen), 72'd1);
        check({tag, "_busy_at_done"}, 72'(busy), 72'd0);
        check({tag, "_win_count"}, 72'(got), 72'd6);
        check({tag, "_pixels"}, 72'(pix), 72'd20);
        check({tag, "_first_latency"}, 72'(first_pix), 72'd13);
        check({tag, "_first_win"}, first_win, FIRST_WIN);
        check({tag, "_last_win"}, last_win, LAST_WIN);
        @(negedge clk);
        check({tag, "_done_pulse_end"}, 72'(frame_done), 72'd0);
        check({tag, "_idle_busy"}, 72'(busy), 72'd0);
        check({tag, "_idle_ready"}, 72'(pixel_in_ready), 72'd0);
    endtask

    initial begin
        int pix;
        int cyc;
        reset          = 1'b1;
        start          = 1'b0;
        pixel_in       = 8'd99;
        pixel_in_valid = 1'b1;
        window_ready   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", 72'(pixel_in_ready), 72'd0);
        check("rst_valid", 72'(window_valid), 72'd0);
        check("rst_done", 72'(frame_done), 72'd0);
        check("rst_busy", 72'(busy), 72'd0);
        check("rst_window", window_out, 72'd0);
        reset = 1'b0;

        // Pixels offered in IDLE must be refused.
        repeat (3) begin
            @(negedge clk);
            #1;
            check("idle_ready", 72'(pixel_in_ready), 72'd0);
            check("idle_busy", 72'(busy), 72'd0);
        end

        do_start(1'b0);
        run_frame(0, 0, 1'b0, "plain");
        do_start(1'b0);
        run_frame(0, 0, 1'b0, "second");
        do_start(1'b0);
        run_frame(1, 0, 1'b0, "stall");
        do_start(1'b0);
        run_frame(0, 1, 1'b0, "gaps");
        do_start(1'b1);
        run_frame(0, 0, 1'b1, "holdstart");

        // Reset in mid-frame, right after pixel 13 is taken.
        do_start(1'b0);
        pix = 0;
        cyc = 0;
        while (pix < 14 && cyc < 100) begin
            @(negedge clk);
            window_ready   = 1'b1;
            pixel_in_valid = 1'b1;
            pixel_in       = 8'(pix);
            #1;
            if (pixel_in_ready) pix++;
            cyc++;
        end
        check("midrst_pixels", 72'(pix), 72'd14);
        @(negedge clk);
        pixel_in_valid = 1'b0;
        check("midrst_pre_valid", 72'(window_valid), 72'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_valid", 72'(window_valid), 72'd0);
        check("midrst_window", window_out, 72'd0);
        check("midrst_busy", 72'(busy), 72'd0);
        check("midrst_ready", 72'(pixel_in_ready), 72'd0);
        check("midrst_done", 72'(frame_done), 72'd0);
        do_start(1'b0);
        run_frame(0, 0, 1'b0, "afterrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Streaming 3x3 window generator between the AXI-Stream pixel input and the MAC array.
- Buffers two image rows in line RAMs plus a 3x3 register window, and emits one full 9-pixel window per accepted pixel once the kernel lies wholly inside the image ('valid' convolution; output is (W-2)x(H-2)).
- Carries its own frame FSM, row/column counters and ready/valid backpressure, so the MAC only sees complete, correctly aligned windows.

Parameters:
- IMG_WIDTH, 224, pixels per row (>=3)
- IMG_HEIGHT, 224, rows per frame (>=3)
- DATA_WIDTH, 8, bits per pixel

Ports:
- clk, input, 1, sole clock
- reset, input, 1, synchronous active-high reset
- start, input, 1, begin a frame; sampled in IDLE only
- pixel_in, input, DATA_WIDTH, raster-order pixel (tdata)
- pixel_in_valid, input, 1, pixel present (tvalid)
- pixel_in_ready, output, 1, block can accept a pixel (tready)
- window_out, output, 9*DATA_WIDTH, packed window; slice k = [k*DATA_WIDTH +: DATA_WIDTH], k = 3*dy+dx; dy=0 is the oldest row, dx=0 the oldest column; k=8 is the newest pixel
- window_valid, output, 1, window_out holds a valid window
- window_ready, input, 1, downstream accepts the window
- frame_done, output, 1, one-cycle pulse at end of frame
- busy, output, 1, high in RUN or DRAIN

Behaviour:
- Interface is decided: one clock `clk`; `reset` is synchronous and active-high.
- Reset (any cycle, including mid-frame):
  - state <= IDLE.
  - pixel_in_ready, window_valid, frame_done and busy = 0; window_out = 0.
  - Counters and shift registers cleared; line-RAM contents need not be cleared.
- Accept: acc = pixel_in_valid & pixel_in_ready.
- pixel_in_ready = (state==RUN) & (!window_valid | window_ready). This is combinational from the registered state, window_valid and window_ready.
- FSM:
  - IDLE: start -> RUN; counters zeroed.
  - RUN: on acc with col==IMG_WIDTH-1 and row==IMG_HEIGHT-1 -> DRAIN.
  - DRAIN: pixel_in_ready=0. When !window_valid, or window_valid & window_ready -> DONE.
  - DONE: frame_done=1 for exactly one cycle -> IDLE.
  - start is ignored outside IDLE.
- Counters (11-bit col, row) advance only on acc. col wraps IMG_WIDTH-1 -> 0 with row+1. row is never incremented past IMG_HEIGHT-1.
- Line buffers: two IMG_WIDTH-deep RAMs, LB0 (previous row) and LB1 (row before that). On acc at column c, in the same cycle:
  - read top = LB1[c] and mid = LB0[c];
  - write LB1[c] <= LB0[c] and LB0[c] <= pixel_in (read-before-write).
- Window registers: 3 rows x 3 columns. On acc, each row shifts left by one column, and the new column {top, mid, pixel_in} enters at dx=2.
- Output register:
  - On acc with row>=2 and col>=2: window_out <= the new 3x3 window, window_valid <= 1, in the cycle after acc (latency 1).
  - Otherwise, window_valid falls on window_ready when no new window is loaded.
  - Simultaneous window handoff and new load: window_valid stays 1 and window_out takes the new data.
- Holding: window_out and window_valid stay stable while window_valid & !window_ready. pixel_in_ready stays low, so no pixel is lost and no window is dropped.
- Row wrap: no window is emitted for col 0 or col 1 of any row; stale shift contents at a row start are never exposed.
- Window count per frame is exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- Pixels presented outside RUN are not accepted (ready=0).

Test Plan (IMG_WIDTH=5, IMG_HEIGHT=4, DATA_WIDTH=8; pixel value = 5*row+col, streamed continuously):
- Reset then start, stream 20 pixels with window_ready=1 -> first window_valid the cycle after pixel 12 is accepted, window_out slices k0..k8 = {0,1,2,5,6,7,10,11,12}. Exactly 6 windows are emitted; the last is {7,8,9,12,13,14,17,18,19}.
- Same stream with window_ready toggling 1 cycle on / 2 cycles off -> pixel_in_ready low whenever window_valid & !window_ready; window_out stable while stalled; the same 6 windows arrive in order with no loss or duplication.
- pixel_in_valid gapped randomly -> counters advance only on acc; window sequence is identical to the first scenario.
- End of frame -> after the last window handshake, frame_done pulses high exactly one cycle; busy drops with it; state returns to IDLE; start in IDLE begins a second frame that yields identical windows.
- Assert reset for one cycle after pixel 13 -> all outputs 0 next cycle. Restarting with start and a full frame yields the same 6 windows as the first scenario.
- start held high during RUN, and pixels driven while in IDLE -> no restart, pixel_in_ready=0 in IDLE, nothing accepted.
